// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-weight 5x5 convolution engine.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package bnn_pkg;

  localparam int DW      = 32;          // pixel / result width
  localparam int K       = 5;           // kernel side
  localparam int W0      = 28;          // input side, layer 1
  localparam int W1      = 12;          // input side, layer 2
  localparam int DIN_LAT = 11;          // start sample -> first pixel on din
  localparam int CW      = $clog2(W0);  // column / row counter width
  localparam int PW      = $clog2(W0 * W0);  // pixel counter width

  typedef enum logic [2:0] {IDLE, SKIP, RUN, DRAIN, FINISH} fsm_e;

  typedef logic signed [DW-1:0] pix_t;

  // A set weight bit adds the pixel, a clear bit subtracts it.
  function automatic pix_t bin_term(input logic w, input pix_t x);
    return w ? x : -x;
  endfunction

endpackage

// File: rtl/bnn_conv_mix_conv_window.sv
// KxK sliding window over a raster pixel stream, built from K-1 line buffers.
// Latency: window and win_vld_o reflect a pushed pixel one cycle after push_i.
// Backpressure: none; a pixel is accepted on every cycle push_i is high.
// Ports: clk_i/rst_ni clock and async active-low reset; clr_i restarts row/column
//   tracking for a new frame; sel_i picks width W1 (1) or W0 (0); push_i/pix_i
//   deliver one pixel; win_o is the window (row 0 oldest, column K-1 newest);
//   win_vld_o flags a window that lies fully inside one frame without row wrap.
module conv_window
  import bnn_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    sel_i,
  input  logic                    push_i,
  input  pix_t                    pix_i,
  output pix_t [K-1:0][K-1:0]     win_o,
  output logic                    win_vld_o
);

  pix_t                lb_q [K-1][W0];   // lb_q[0] = previous row, lb_q[K-2] = oldest row
  pix_t [K-1:0][K-1:0] win_q;
  logic                win_vld_q;
  logic [CW-1:0]       col_q;
  logic [CW-1:0]       row_q;
  logic [CW-1:0]       col_last;
  pix_t                tap [K];          // one column of the window, tap[0] = top row

  assign col_last = sel_i ? CW'(W1 - 1) : CW'(W0 - 1);

  // Line buffers are addressed by column, so each read returns the pixel
  // from exactly one row earlier at the same column.
  always_comb begin
    tap[K-1] = pix_i;
    for (int i = 0; i < K - 1; i++) begin
      tap[K-2-i] = lb_q[i][col_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q     <= '0;
      row_q     <= '0;
      win_vld_q <= 1'b0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          win_q[i][j] <= '0;
        end
      end
      for (int i = 0; i < K - 1; i++) begin
        for (int c = 0; c < W0; c++) begin
          lb_q[i][c] <= '0;
        end
      end
    end else begin
      win_vld_q <= 1'b0;
      if (clr_i) begin
        col_q <= '0;
        row_q <= '0;
      end else if (push_i) begin
        // Column >= K-1 guarantees the window does not straddle a row wrap.
        win_vld_q <= (row_q >= CW'(K - 1)) && (col_q >= CW'(K - 1));
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K - 1; j++) begin
            win_q[i][j] <= win_q[i][j+1];
          end
          win_q[i][K-1] <= tap[i];
        end
        lb_q[0][col_q] <= pix_i;
        for (int i = 1; i < K - 1; i++) begin
          lb_q[i][col_q] <= lb_q[i-1][col_q];
        end
        if (col_q == col_last) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign win_o     = win_q;
  assign win_vld_o = win_vld_q;

endmodule

// File: rtl/bnn_conv_mix.sv
// Binary-weight 5x5 valid-mode convolution over a 28x28 or 12x12 raster frame.
// Latency: result appears 3 cycles after its closing pixel is sampled; din read DIN_LAT cycles after start.
// Backpressure: none; din is consumed one pixel per cycle during RUN, results are not stallable.
// Ports: clk/rstn clock and async active-low reset; start launches a frame on a
//   rising level; weight_en/weight load the 25-bit sign kernel; din pixel stream;
//   state selects the layer; ovalid/dout result stream; done marks the last result.
module bnn_conv_mix
  import bnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 weight_en,
  input  logic                 weight,
  input  logic signed [DW-1:0] din,
  input  logic                 state,
  output logic                 ovalid,
  output logic                 done,
  output logic signed [DW-1:0] dout
);

  fsm_e                fsm_q;
  logic                start_q;
  logic                wsel_q;
  logic [3:0]          skip_cnt_q;
  logic [PW-1:0]       pix_cnt_q;
  logic [1:0]          drain_cnt_q;
  logic [PW-1:0]       pix_last;
  logic                launch;
  logic                push;
  logic                clr;

  logic [K*K-1:0]      kern_q;
  logic [4:0]          wcnt_q;

  pix_t [K-1:0][K-1:0] win;
  logic                win_vld;
  logic                last_win_q;

  pix_t                rsum_d [K];
  pix_t                rsum_q [K];
  pix_t                tot_d;
  pix_t                tot_q;
  logic                v1_q, v2_q, l1_q, l2_q;
  logic                ovalid_q, done_q;
  pix_t                dout_q;

  // start_q resets low, so start already high when reset releases counts as a launch.
  assign launch   = start && !start_q;
  assign clr      = (fsm_q == IDLE) && launch;
  assign push     = (fsm_q == RUN);
  assign pix_last = wsel_q ? PW'(W1 * W1 - 1) : PW'(W0 * W0 - 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_q       <= IDLE;
      start_q     <= 1'b0;
      wsel_q      <= 1'b0;
      skip_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      drain_cnt_q <= '0;
      last_win_q  <= 1'b0;
    end else begin
      start_q    <= start;
      last_win_q <= push && (pix_cnt_q == pix_last);
      case (fsm_q)
        IDLE: begin
          if (launch) begin
            fsm_q      <= SKIP;
            wsel_q     <= state;
            skip_cnt_q <= '0;
            pix_cnt_q  <= '0;
          end
        end
        // Leaving SKIP on its (DIN_LAT-1)th cycle puts pixel 0 on the
        // DIN_LAT-th edge after start was sampled.
        SKIP: begin
          if (skip_cnt_q == 4'(DIN_LAT - 2)) begin
            fsm_q <= RUN;
          end else begin
            skip_cnt_q <= skip_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (pix_cnt_q == pix_last) begin
            fsm_q       <= DRAIN;
            drain_cnt_q <= '0;
          end else begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
          end
        end
        // Three cycles covers window -> row sums -> total -> output register.
        DRAIN: begin
          if (drain_cnt_q == 2'd2) begin
            fsm_q <= FINISH;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        FINISH: begin
          if (!start) begin
            fsm_q <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // Kernel load: first sampled bit of a weight_en burst is dropped, the next
  // K*K bits shift in from the top so bit 0 ends up as k[0][0].
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kern_q <= '0;
      wcnt_q <= '0;
    end else if (!weight_en) begin
      wcnt_q <= '0;
    end else if (wcnt_q == 5'd0) begin
      wcnt_q <= 5'd1;
    end else if (wcnt_q <= 5'(K * K)) begin
      kern_q <= {weight, kern_q[K*K-1:1]};
      wcnt_q <= wcnt_q + 1'b1;
    end
  end

  conv_window u_win (
    .clk_i     (clk),
    .rst_ni    (rstn),
    .clr_i     (clr),
    .sel_i     (wsel_q),
    .push_i    (push),
    .pix_i     (din),
    .win_o     (win),
    .win_vld_o (win_vld)
  );

  always_comb begin
    for (int i = 0; i < K; i++) begin
      rsum_d[i] = '0;
      for (int j = 0; j < K; j++) begin
        rsum_d[i] = rsum_d[i] + bin_term(kern_q[i*K+j], win[i][j]);
      end
    end
  end

  always_comb begin
    tot_d = '0;
    for (int i = 0; i < K; i++) begin
      tot_d = tot_d + rsum_q[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < K; i++) begin
        rsum_q[i] <= '0;
      end
      tot_q    <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      l1_q     <= 1'b0;
      l2_q     <= 1'b0;
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      for (int i = 0; i < K; i++) begin
        rsum_q[i] <= rsum_d[i];
      end
      tot_q    <= tot_d;
      v1_q     <= win_vld;
      l1_q     <= last_win_q;
      v2_q     <= v1_q;
      l2_q     <= l1_q;
      ovalid_q <= v2_q;
      done_q   <= v2_q && l2_q;
      if (v2_q) begin
        dout_q <= tot_q;
      end
    end
  end

  assign ovalid = ovalid_q;
  assign done   = done_q;
  assign dout   = dout_q;

endmodule

// File: tb/tb_bnn_conv_mix.sv
// Directed bench for bnn_conv_mix: kernel loads, frames at both sizes, mid-frame reset.
// Latency: checks every result lands exactly 3 cycles after its closing pixel.
// Backpressure: n/a.
module tb_bnn_conv_mix;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic               weight_en;
  logic               weight;
  logic signed [31:0] din;
  logic               state;
  logic               ovalid;
  logic               done;
  logic signed [31:0] dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bnn_conv_mix dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .weight_en (weight_en),
    .weight    (weight),
    .din       (din),
    .state     (state),
    .ovalid    (ovalid),
    .done      (done),
    .dout      (dout)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drop bit first, then kb[0]=k[0][0] .. kb[24]=k[4][4], then a few toggling
  // bits with weight_en still high that must not reach the kernel.
  task automatic load_kernel(input logic [24:0] kb, input logic disc);
    @(posedge clk); #1;
    weight_en = 1'b1;
    weight    = disc;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      weight = kb[n];
    end
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      weight = ~weight;
    end
    @(posedge clk); #1;
    weight_en = 1'b0;
    weight    = 1'b0;
    @(posedge clk); #1;
  endtask

  // pat 0: every pixel = cval, every result = expc.
  // pat 1: pixel = raster index with centre-only kernel; the window is linear in
  //        the index, so S = 25*centre and the result is -23*centre.
  task automatic run_frame(input logic sel, input int pat, input int cval,
                           input int expc, input string tag);
    int w, npx, nout, m, dones, kend, n, orow, ocol, ncl, e;
    w     = sel ? 12 : 28;
    npx   = w * w;
    nout  = (w - 4) * (w - 4);
    m     = 0;
    dones = 0;
    state = sel;
    @(posedge clk); #1;
    start = 1'b1;
    // k = 0 is the edge that first samples start high; pixel n is sampled on edge 11+n.
    kend = 14 + npx + 100;
    for (int k = 0; k < kend; k++) begin
      @(posedge clk); #1;
      if (k == 1) state = ~sel;
      n = k - 10;
      if (n >= 0 && n < npx) din = (pat == 0) ? cval : n;
      else                   din = 32'hDEAD_BEEF;
      if (ovalid) begin
        if (m < nout) begin
          orow = m / (w - 4);
          ocol = m % (w - 4);
          ncl  = (orow + 4) * w + ocol + 4;
          e    = (pat == 0) ? expc : -23 * ((orow + 2) * w + ocol + 2);
          chk($sformatf("%s_lat[%0d]", tag, m), k, 14 + ncl);
          chk($sformatf("%s_val[%0d]", tag, m), dout, e);
          chk($sformatf("%s_done[%0d]", tag, m), int'(done), int'(m == nout - 1));
        end
        m++;
      end else if (done) begin
        chk($sformatf("%s_done_no_valid", tag), 1, 0);
      end
      if (done) dones++;
    end
    chk($sformatf("%s_count", tag), m, nout);
    chk($sformatf("%s_ndone", tag), dones, 1);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [24:0] kb;
  int          quiet;

  initial begin
    rstn      = 1'b0;
    start     = 1'b0;
    weight_en = 1'b0;
    weight    = 1'b0;
    din       = '0;
    state     = 1'b0;
    #2;
    chk("rst_ovalid", int'(ovalid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dout", dout, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Test 1: all +1 weights, unit pixels, 28x28.
    load_kernel('1, 1'b0);
    run_frame(1'b0, 0, 1, 25, "ones28");

    // Test 2: all -1 weights.
    load_kernel('0, 1'b1);
    run_frame(1'b0, 0, 1, -25, "zeros28");

    // Test 3: centre weight only, raster-index pixels.
    kb = 25'd1 << 12;
    load_kernel(kb, 1'b1);
    run_frame(1'b0, 1, 0, 0, "centre28");

    // Test 4: 12x12 layer, all +1 weights, pixels of 2; start held through the tail.
    load_kernel('1, 1'b0);
    run_frame(1'b1, 0, 2, 50, "ones12");

    // Test 5: reset in the middle of RUN.
    din   = 32'sd1;
    state = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    rstn  = 1'b0;
    start = 1'b0;
    #2;
    chk("midrst_ovalid", int'(ovalid), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_dout", dout, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    quiet = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (ovalid || done) quiet++;
    end
    chk("midrst_quiet", quiet, 0);
    // Reset cleared the kernel, so every tap acts as -1.
    run_frame(1'b1, 0, 2, -50, "nokern12");
    load_kernel('1, 1'b0);
    run_frame(1'b1, 0, 2, 50, "after_rst12");

    // Test 6: alternating weights 1,0,1,..., dropped bit 0, pixels of -1.
    for (int n = 0; n < 25; n++) kb[n] = (n % 2 == 0);
    load_kernel(kb, 1'b0);
    run_frame(1'b1, 0, -1, -1, "alt12");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
